// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt request / priority path.
package irq_pkg;

  localparam int           NUM_IR             = 8;
  localparam logic [2:0]   RESET_LOWEST_LEVEL = 3'd7;

  // Decoded one-hot level: index is meaningful only when valid is set.
  typedef struct packed {
    logic       valid;
    logic [2:0] index;
  } level_idx_t;

  // Converts a one-hot vector to its bit index; valid is 0 for zero or
  // multi-hot inputs.
  function automatic level_idx_t onehot_to_index(input logic [NUM_IR-1:0] vec);
    level_idx_t res;
    int         ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < NUM_IR; i++) begin
      if (vec[i]) begin
        res.index = 3'(i);
        ones      = ones + 1;
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/rotating_priority_encoder.sv
// Circular find-first: level lowest_level+1 (mod 8) is highest priority,
// lowest_level itself is lowest. Output is one-hot or zero.
module rotating_priority_encoder
  import irq_pkg::*;
(
  input  logic [NUM_IR-1:0] request,
  input  logic [2:0]        lowest_level,
  output logic [NUM_IR-1:0] winner
);

  logic       found;
  logic [2:0] idx;

  // Walk the levels from highest to lowest priority and keep the first hit.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_IR; k++) begin
      idx = lowest_level + 3'(k + 1);
      if (!found && request[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irr_priority_resolver.sv
// Interrupt request register with edge/level capture, masking, in-service
// blocking and rotating priority resolution. IRR is captured on the edge
// that samples the pins; the winner and INT follow one edge later.
module irr_priority_resolver
  import irq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_IR-1:0] interrupt_request_pin,
  input  logic              level_or_edge_triggered_config,
  input  logic              freeze,
  input  logic [NUM_IR-1:0] clear_interrupt_request,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic [NUM_IR-1:0] in_service_register,
  input  logic              special_mask_mode,
  input  logic              rotate_request,
  input  logic [NUM_IR-1:0] last_serviced,
  output logic [NUM_IR-1:0] interrupt_request_register,
  output logic [NUM_IR-1:0] highest_priority_interrupt,
  output logic              interrupt,
  output logic [2:0]        lowest_priority_level
);

  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] hist_q, hist_d;
  logic [NUM_IR-1:0] hpi_q, hpi_d;
  logic              int_q, int_d;
  logic [2:0]        lpl_q, lpl_d;

  logic [NUM_IR-1:0] candidates;
  logic [NUM_IR-1:0] cand_request;
  logic [NUM_IR-1:0] cand_winner;
  logic [NUM_IR-1:0] isr_winner;
  level_idx_t        cand_idx;
  level_idx_t        isr_idx;
  level_idx_t        last_idx;
  logic [2:0]        cand_rank;
  logic [2:0]        isr_rank;

  // Capture requests; freeze holds IRR and pin history, clear always applies.
  always_comb begin
    hist_d = hist_q;
    irr_d  = irr_q;
    if (!freeze) begin
      hist_d = interrupt_request_pin;
      if (level_or_edge_triggered_config) begin
        irr_d = interrupt_request_pin;
      end else begin
        irr_d = (irr_q | (interrupt_request_pin & ~hist_q)) & interrupt_request_pin;
      end
    end
    irr_d = irr_d & ~clear_interrupt_request;
  end

  assign candidates   = irr_q & ~interrupt_mask;
  assign cand_request = special_mask_mode ? (candidates & ~in_service_register) : candidates;

  rotating_priority_encoder u_cand_enc (
    .request      (cand_request),
    .lowest_level (lpl_q),
    .winner       (cand_winner)
  );

  rotating_priority_encoder u_isr_enc (
    .request      (in_service_register),
    .lowest_level (lpl_q),
    .winner       (isr_winner)
  );

  // Rank 0 is the highest-priority level under the current rotation.
  always_comb begin
    cand_idx  = onehot_to_index(cand_winner);
    isr_idx   = onehot_to_index(isr_winner);
    cand_rank = cand_idx.index - lpl_q - 3'd1;
    isr_rank  = isr_idx.index - lpl_q - 3'd1;
  end

  // Resolve the winner: the top candidate must outrank the top in-service
  // level unless special mask mode already removed in-service levels.
  always_comb begin
    hpi_d = hpi_q;
    int_d = int_q;
    if (!freeze) begin
      hpi_d = '0;
      if (cand_idx.valid &&
          (special_mask_mode || !isr_idx.valid || (cand_rank < isr_rank))) begin
        hpi_d = cand_winner;
      end
      int_d = |hpi_d;
    end
  end

  // Rotation loads only from a clean one-hot last_serviced.
  always_comb begin
    last_idx = onehot_to_index(last_serviced);
    lpl_d    = lpl_q;
    if (rotate_request && last_idx.valid) begin
      lpl_d = last_idx.index;
    end
  end

  // State registers; reset overrides freeze at once.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (reset) begin
      irr_q  <= '0;
      hist_q <= '1;
      hpi_q  <= '0;
      int_q  <= 1'b0;
      lpl_q  <= RESET_LOWEST_LEVEL;
    end else begin
      irr_q  <= irr_d;
      hist_q <= hist_d;
      hpi_q  <= hpi_d;
      int_q  <= int_d;
      lpl_q  <= lpl_d;
    end
  end

  assign interrupt_request_register = irr_q;
  assign highest_priority_interrupt = hpi_q;
  assign interrupt                  = int_q;
  assign lowest_priority_level      = lpl_q;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Directed table-driven bench for irr_priority_resolver plus hand-written
// sequences for reset-release edge suppression and reset during freeze.
module tb_irr_priority_resolver;

  logic       clock;
  logic       reset;
  logic [7:0] pin;
  logic       lvl;
  logic       frz;
  logic [7:0] clr;
  logic [7:0] msk;
  logic [7:0] isr;
  logic       smm;
  logic       rot;
  logic [7:0] last;
  logic [7:0] irr_o;
  logic [7:0] hpi_o;
  logic       int_o;
  logic [2:0] lpl_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] pin;
    logic       lvl;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] msk;
    logic [7:0] isr;
    logic       smm;
    logic       rot;
    logic [7:0] last;
    logic [7:0] exp_irr;
    logic [7:0] exp_hpi;
    logic       exp_int;
    logic [2:0] exp_lpl;
  } vec_t;

  vec_t vq[$];

  irr_priority_resolver dut (
    .clock                          (clock),
    .reset                          (reset),
    .interrupt_request_pin          (pin),
    .level_or_edge_triggered_config (lvl),
    .freeze                         (frz),
    .clear_interrupt_request        (clr),
    .interrupt_mask                 (msk),
    .in_service_register            (isr),
    .special_mask_mode              (smm),
    .rotate_request                 (rot),
    .last_serviced                  (last),
    .interrupt_request_register     (irr_o),
    .highest_priority_interrupt     (hpi_o),
    .interrupt                      (int_o),
    .lowest_priority_level          (lpl_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] p, input logic l, input logic f, input logic [7:0] c,
                     input logic [7:0] m, input logic [7:0] s, input logic sm, input logic r,
                     input logic [7:0] ls, input logic [7:0] ei, input logic [7:0] eh,
                     input logic en, input logic [2:0] el);
    vec_t v;
    v = '{p, l, f, c, m, s, sm, r, ls, ei, eh, en, el};
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    pin = 8'h00; lvl = 1'b0; frz = 1'b0; clr = 8'h00; msk = 8'h00;
    isr = 8'h00; smm = 1'b0; rot = 1'b0; last = 8'h00;
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag, input logic [7:0] ei, input logic [7:0] eh,
                           input logic en, input logic [2:0] el);
    check({tag, " irr"}, irr_o, ei);
    check({tag, " hpi"}, hpi_o, eh);
    check({tag, " int"}, {7'd0, int_o}, {7'd0, en});
    check({tag, " lpl"}, {5'd0, lpl_o}, {5'd0, el});
  endtask

  initial begin
    //   pin   lvl frz clr    msk    isr    smm rot last  | irr    hpi    int lpl
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 0
    add(8'h20, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h20, 8'h00, 0, 3'd7); // 1 edge 1
    add(8'h20, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h20, 8'h20, 1, 3'd7); // 2 edge 2
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h20, 1, 3'd7); // 3
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 4
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h81, 8'h00, 0, 3'd7); // 5
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h81, 8'h01, 1, 3'd7); // 6
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h01,  8'h81, 8'h01, 1, 3'd0); // 7 rotate
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h81, 8'h80, 1, 3'd0); // 8
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h03,  8'h81, 8'h80, 1, 3'd0); // 9 multi-hot
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00,  8'h81, 8'h80, 1, 3'd0); // 10 zero
    add(8'h81, 0, 0, 8'h00, 8'h80, 8'h00, 0, 0, 8'h00,  8'h81, 8'h01, 1, 3'd0); // 11 mask
    add(8'h81, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h80,  8'h81, 8'h80, 1, 3'd7); // 12
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h01, 1, 3'd7); // 13
    add(8'h0C, 1, 0, 8'h00, 8'h00, 8'h04, 0, 0, 8'h00,  8'h0C, 8'h00, 0, 3'd7); // 14
    add(8'h0C, 1, 0, 8'h00, 8'h00, 8'h04, 0, 0, 8'h00,  8'h0C, 8'h00, 0, 3'd7); // 15 blocked
    add(8'h0C, 1, 0, 8'h00, 8'h00, 8'h04, 1, 0, 8'h00,  8'h0C, 8'h08, 1, 3'd7); // 16 smm
    add(8'h0C, 1, 0, 8'h00, 8'h00, 8'h08, 0, 0, 8'h00,  8'h0C, 8'h04, 1, 3'd7); // 17
    add(8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h04, 1, 3'd7); // 18
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 19
    add(8'h02, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 20 frozen
    add(8'h02, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 21
    add(8'h02, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h02, 8'h00, 0, 3'd7); // 22
    add(8'h02, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h02, 8'h02, 1, 3'd7); // 23
    add(8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h02, 8'h02, 1, 3'd7); // 24 hold
    add(8'h00, 0, 1, 8'h02, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h02, 1, 3'd7); // 25 clear
    add(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 26
    add(8'h08, 0, 0, 8'h08, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 27 clr wins
    add(8'h08, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h00, 8'h00, 0, 3'd7); // 28
    add(8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h08, 8'h00, 0, 3'd7); // 29 level
    add(8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,  8'h08, 8'h08, 1, 3'd7); // 30

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all("reset", 8'h00, 8'h00, 1'b0, 3'd7);
    reset = 1'b0;

    foreach (vq[i]) begin
      pin  = vq[i].pin;  lvl = vq[i].lvl; frz = vq[i].frz; clr = vq[i].clr;
      msk  = vq[i].msk;  isr = vq[i].isr; smm = vq[i].smm; rot = vq[i].rot;
      last = vq[i].last;
      step();
      check_all($sformatf("vec%0d", i), vq[i].exp_irr, vq[i].exp_hpi,
                vq[i].exp_int, vq[i].exp_lpl);
    end

    // Pins held high through reset release must not look like edges.
    drive_idle();
    pin   = 8'hFF;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("held%0d irr", n), irr_o, 8'h00);
      check($sformatf("held%0d int", n), {7'd0, int_o}, 8'h00);
    end
    pin = 8'hFE;
    step();
    check("fall irr", irr_o, 8'h00);
    pin = 8'hFF;
    step();
    check("rise irr", irr_o, 8'h01);
    step();
    check("rise hpi", hpi_o, 8'h01);
    check("rise int", {7'd0, int_o}, 8'h01);

    // Freeze holds the winner while rotation still loads; reset mid-freeze
    // clears everything without waiting for a clock edge.
    frz  = 1'b1;
    rot  = 1'b1;
    last = 8'h10;
    step();
    check("frz hpi", hpi_o, 8'h01);
    check("frz lpl", {5'd0, lpl_o}, 8'h04);
    rot = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async irr", irr_o, 8'h00);
    check("async hpi", hpi_o, 8'h00);
    check("async int", {7'd0, int_o}, 8'h00);
    check("async lpl", {5'd0, lpl_o}, 8'h07);
    @(negedge clock);
    reset = 1'b0;
    frz   = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
